// File: rtl/sample_out_buffer.sv
// rtl/sample_out_buffer.sv - output sample FIFO between filter and I2S/DAC framing
// Primes to half full before playing, mutes while priming, repeats last sample on underrun.
module sample_out_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [WIDTH-1:0]           in_sample,
   input  logic                       in_valid,
   input  logic                       frame_req,
   input  logic [1:0]                 gain_shift,
   output logic [WIDTH-1:0]           out_sample,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic [7:0]                 underrun_cnt,
   output logic [7:0]                 overflow_cnt,
   output logic                       running
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t            state;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [LW-1:0]     level_r;
   logic [LW-1:0]     level_next;

   logic              active;
   logic              pop_req;
   logic              do_pop;
   logic              underrun;
   logic              full;
   logic              push_try;
   logic              do_push;
   logic              drop;

   logic [WIDTH-1:0]  head;
   logic [WIDTH+2:0]  head_ext;
   logic [WIDTH+2:0]  shifted;
   logic [WIDTH-1:0]  gained;

   always_comb begin
      active     = enable && (state != IDLE);
      pop_req    = active && frame_req;
      do_pop     = pop_req && (state == RUN) && (level_r != '0);
      underrun   = pop_req && (state == RUN) && (level_r == '0);
      full       = (level_r == LW'(DEPTH));
      push_try   = active && in_valid;
      // a full FIFO still takes the push when the same cycle pops
      do_push    = push_try && (!full || do_pop);
      drop       = push_try && full && !do_pop;
      level_next = level_r + LW'(do_push) - LW'(do_pop);
   end

   // Gain in WIDTH+3 bits; any disagreement in the top four bits means it left range
   always_comb begin
      head     = mem[rd_ptr];
      head_ext = {{3{head[WIDTH-1]}}, head};
      shifted  = head_ext << gain_shift;
      gained   = shifted[WIDTH-1:0];
      if (shifted[WIDTH+2:WIDTH-1] != '0 && shifted[WIDTH+2:WIDTH-1] != '1)
         gained = shifted[WIDTH+2] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= in_sample;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         level_r      <= '0;
         out_sample   <= '0;
         out_valid    <= 1'b0;
         underrun_cnt <= '0;
         overflow_cnt <= '0;
      end else if (!enable) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level_r   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state     <= PRIME;
               out_valid <= 1'b0;
            end
            PRIME, RUN: begin
               out_valid <= pop_req;
               if (pop_req && state == PRIME)
                  out_sample <= '0;
               else if (do_pop)
                  out_sample <= gained;
               if (do_pop)
                  rd_ptr <= rd_ptr + AW'(1);
               if (do_push)
                  wr_ptr <= wr_ptr + AW'(1);
               level_r <= level_next;
               if (underrun && underrun_cnt != 8'hFF)
                  underrun_cnt <= underrun_cnt + 8'd1;
               if (drop && overflow_cnt != 8'hFF)
                  overflow_cnt <= overflow_cnt + 8'd1;
               if (underrun)
                  state <= PRIME;
               else if (state == PRIME && level_next >= LW'(DEPTH / 2))
                  state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign level   = level_r;
   assign running = (state == RUN);

endmodule

// File: tb/tb_sample_out_buffer.sv
// tb/tb_sample_out_buffer.sv - randomized bench for sample_out_buffer against a queue model
module tb_sample_out_buffer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [WIDTH-1:0]  in_sample;
   logic              in_valid;
   logic              frame_req;
   logic [1:0]        gain_shift;
   logic [WIDTH-1:0]  out_sample;
   logic              out_valid;
   logic [2:0]        level;
   logic [7:0]        underrun_cnt;
   logic [7:0]        overflow_cnt;
   logic              running;

   sample_out_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .in_sample    (in_sample),
      .in_valid     (in_valid),
      .frame_req    (frame_req),
      .gain_shift   (gain_shift),
      .out_sample   (out_sample),
      .out_valid    (out_valid),
      .level        (level),
      .underrun_cnt (underrun_cnt),
      .overflow_cnt (overflow_cnt),
      .running      (running)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference: mode 0 idle, 1 priming, 2 playing; samples held as plain ints
   int q[$];
   int m_mode;
   int m_out;
   int m_valid;
   int m_under;
   int m_over;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_gain(input int head, input int g);
      longint p;
      p = longint'(head) * (longint'(1) << g);
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      return int'(p);
   endfunction

   task automatic model_reset();
      q.delete();
      m_mode = 0; m_out = 0; m_valid = 0; m_under = 0; m_over = 0;
   endtask

   task automatic model_step(input bit en, input bit v, input int s, input bit f, input int g);
      bit popped, under;
      if (!en) begin
         m_mode = 0; m_valid = 0; q.delete();
      end else if (m_mode == 0) begin
         m_mode = 1; m_valid = 0;
      end else begin
         popped = 0; under = 0;
         m_valid = f;
         if (f) begin
            if (m_mode == 1) m_out = 0;
            else if (q.size() > 0) begin m_out = sat_gain(q.pop_front(), g); popped = 1; end
            else begin under = 1; if (m_under < 255) m_under++; end
         end
         if (v) begin
            if (q.size() < DEPTH) q.push_back(s);
            else if (m_over < 255) m_over++;
         end
         if (under) m_mode = 1;
         else if (m_mode == 1 && q.size() >= DEPTH / 2) m_mode = 2;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".out_valid"}, int'(out_valid), m_valid);
      check({tag, ".out_sample"}, int'(out_sample), m_out & 32'hFFFF);
      check({tag, ".level"}, int'(level), q.size());
      check({tag, ".running"}, int'(running), int'(m_mode == 2));
      check({tag, ".underrun_cnt"}, int'(underrun_cnt), m_under);
      check({tag, ".overflow_cnt"}, int'(overflow_cnt), m_over);
   endtask

   task automatic step(input string tag, input bit en, input bit v, input int s, input bit f, input int g);
      logic [31:0] sv;
      sv = s;
      enable = en; in_valid = v; in_sample = sv[15:0]; frame_req = f; gain_shift = 2'(g);
      model_step(en, v, s, f, g);
      @(posedge clk); #1;
      compare_all(tag);
      in_valid = 1'b0; frame_req = 1'b0;
   endtask

   initial begin
      shortint rs;
      rst_n = 1'b0; enable = 1'b0; in_sample = '0; in_valid = 1'b0; frame_req = 1'b0; gain_shift = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      rst_n = 1'b1;

      // prime with two samples, then play them
      step("en", 1, 0, 0, 0, 0);
      step("push100", 1, 1, 100, 0, 0);
      step("push200", 1, 1, 200, 0, 0);
      check("run_after_two", int'(running), 1);
      step("pop100", 1, 0, 0, 1, 0);
      check("first_out", int'(out_sample), 100);
      step("after_pop", 1, 0, 0, 0, 0);
      check("valid_one_cycle", int'(out_valid), 0);
      step("pop200", 1, 0, 0, 1, 0);
      step("push300", 1, 1, 300, 0, 0);
      step("pop300", 1, 0, 0, 1, 2);
      step("underrun", 1, 0, 0, 1, 3);
      check("underrun_repeat", int'(out_sample), 1200);
      check("underrun_cnt1", int'(underrun_cnt), 1);
      check("underrun_to_prime", int'(running), 0);

      // mute frame while priming
      step("prime_push", 1, 1, 7, 0, 0);
      step("prime_frame", 1, 0, 0, 1, 0);
      check("mute_sample", int'(out_sample), 0);
      check("mute_level", int'(level), 1);

      // fill, overflow, push+pop at full
      step("fill2", 1, 1, 8, 0, 0);
      step("fill3", 1, 1, 9, 0, 0);
      step("fill4", 1, 1, 10, 0, 0);
      step("overflow", 1, 1, 11, 0, 0);
      check("ovf_cnt1", int'(overflow_cnt), 1);
      step("full_pushpop", 1, 1, 12, 1, 0);
      check("full_pushpop_level", int'(level), 4);
      check("full_pushpop_ovf", int'(overflow_cnt), 1);

      // flush, then gain saturation cases
      step("flush", 0, 0, 0, 0, 0);
      step("reen", 1, 0, 0, 0, 0);
      step("g_a", 1, 1, 32'h1000, 0, 0);
      step("g_b", 1, 1, -32'sh1000, 0, 0);
      step("g_c", 1, 1, 32'h0100, 0, 0);
      step("gpop_a", 1, 0, 0, 1, 3);
      check("gain_pos_sat", int'(out_sample), 32'h7FFF);
      step("gpop_b", 1, 0, 0, 1, 3);
      check("gain_neg_sat", int'(out_sample), 32'h8000);
      step("gpop_c", 1, 0, 0, 1, 3);
      check("gain_nosat", int'(out_sample), 32'h0800);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rs = shortint'($urandom);
         if ($urandom_range(0, 2) != 0) rs = shortint'($signed(16'($urandom_range(0, 8191))) - 16'sd4096);
         step("rand", $urandom_range(0, 40) != 0, $urandom_range(0, 1) == 1, int'(rs),
              $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
      end

      // forced underruns until the counter pins
      for (int i = 0; i < 300; i++) begin
         step("u_push", 1, 1, i, 0, 0);
         step("u_push", 1, 1, i + 1, 0, 0);
         step("u_pop", 1, 0, 0, 1, 0);
         step("u_pop", 1, 0, 0, 1, 0);
         step("u_under", 1, 0, 0, 1, 0);
      end
      check("underrun_sat", int'(underrun_cnt), 255);

      // reset in the middle of traffic
      step("r_push", 1, 1, 55, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_reset");
      @(posedge clk); #1;
      compare_all("held_reset");
      rst_n = 1'b1;
      step("post_rst_idle", 1, 0, 0, 0, 0);
      step("post_rst_push", 1, 1, 77, 0, 0);
      check("post_rst_level", int'(level), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sample_out_buffer.md
SAMPLE_OUT_BUFFER -- requirements
Module: sample_out_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter WIDTH, default 16, signed sample width.
REQ-003 clk  input  1  single clock domain, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  block active; driven from init_done.
REQ-006 in_sample  input  WIDTH  signed filter output sample.
REQ-007 in_valid  input  1  one-cycle push strobe for in_sample.
REQ-008 frame_req  input  1  one-cycle pop strobe from the I2S transmit framing, once per frame.
REQ-009 gain_shift  input  2  left-shift output gain, 0..3.
REQ-010 out_sample  output  WIDTH  registered signed sample for the DAC path.
REQ-011 out_valid  output  1  one-cycle strobe qualifying out_sample.
REQ-012 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 underrun_cnt  output  8  saturating underrun event count.
REQ-014 overflow_cnt  output  8  saturating dropped-sample count.
REQ-015 running  output  1  high while in RUN state.

Function
REQ-016 Storage: circular FIFO, DEPTH x WIDTH, read/write pointers wrap modulo DEPTH; level = pushes minus pops.
REQ-017 States: IDLE, PRIME, RUN; running = (state == RUN).
REQ-018 IDLE: entered whenever enable = 0 (any state, next edge); FIFO flushed (level -> 0); pushes ignored; frame_req ignored; counters hold.
REQ-019 IDLE -> PRIME when enable = 1.
REQ-020 PRIME: pushes accepted; frame_req produces out_valid with out_sample = 0 (mute), no pop, no underrun count.
REQ-021 PRIME -> RUN on the edge where level reaches >= DEPTH/2 after the update.
REQ-022 RUN, frame_req with level > 0: pop head, out_sample = sat(head << gain_shift), out_valid next cycle.
REQ-023 RUN, frame_req with level == 0: out_sample repeats previous out_sample, out_valid asserted, underrun_cnt += 1, next state PRIME.
REQ-024 Latency: frame_req at cycle N -> out_valid high exactly in cycle N+1, low otherwise; exactly one out_valid per accepted frame_req.
REQ-025 Push when level == DEPTH and no pop the same cycle: new sample dropped, FIFO unchanged, overflow_cnt += 1.
REQ-026 Simultaneous push and pop: pop uses head before the push; if full, push succeeds (no overflow); if empty, pop is an underrun per REQ-023 and the push is stored.
REQ-027 Gain: shift in WIDTH+3 bits, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; gain_shift sampled in the pop cycle.
REQ-028 Counters saturate at 255, never wrap; cleared only by reset.
REQ-029 gain_shift changes take effect on the next pop only; no effect on a repeated sample.

Reset
REQ-030 rst_n low: state IDLE, pointers and level 0, out_sample 0, out_valid 0, underrun_cnt 0, overflow_cnt 0, running 0.
REQ-031 Reset asserted mid-operation discards all buffered samples; after release the block re-enters PRIME only when enable is high.

Verification
REQ-032 enable = 1, push 100, 200 (DEPTH 4), then frame_req -> state RUN after second push; out_sample = 100, out_valid in the following cycle only.
REQ-033 In PRIME with level 1, frame_req -> out_valid with out_sample = 0; level stays 1; underrun_cnt stays 0.
REQ-034 RUN, level 0, last output 300, frame_req -> out_sample = 300, underrun_cnt = 1, running drops next cycle.
REQ-035 Fill to 4, push 5th sample -> overflow_cnt = 1, level 4; push and frame_req together when full -> level 4, no overflow increment.
REQ-036 gain_shift = 3, head 0x1000 -> out_sample 0x7FFF; head -0x1000 -> 0x8000; head 0x0100 -> 0x0800.
REQ-037 Drive 300 forced underruns -> underrun_cnt = 255; assert rst_n low mid-stream -> all outputs 0, level 0.
